// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes the instruction, builds ALU operands and op code, registers them under valid/ready.
// Define FWD_EN to forward EX/MEM and MEM/WB results into the rs/rt operands.
module alu_issue_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  output logic        id_ready,
  input  logic [15:0] id_instr,
  input  logic [15:0] rs_data,
  input  logic [15:0] rt_data,
  input  logic        flush,
  input  logic        ex_ready,
  output logic        ex_valid,
  output logic [15:0] ex_inputA,
  output logic [15:0] ex_inputB,
  output logic [2:0]  ex_alu_control,
  output logic [2:0]  ex_rd,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic [15:0] ex_store_data,
  output logic        ex_illegal,
  input  logic        exmem_reg_write,
  input  logic [2:0]  exmem_rd,
  input  logic [15:0] exmem_result,
  input  logic        memwb_reg_write,
  input  logic [2:0]  memwb_rd,
  input  logic [15:0] memwb_result
);

  typedef enum logic [3:0] {
    OP_RTYPE = 4'b0000,
    OP_ADDI  = 4'b0001,
    OP_LW    = 4'b0010,
    OP_SW    = 4'b0011,
    OP_BEQ   = 4'b0100
  } opcode_e;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_AND = 3'b010,
    ALU_OR  = 3'b011,
    ALU_SLT = 3'b100
  } alu_op_e;

  logic [3:0]  op;
  logic [2:0]  rs_idx;
  logic [2:0]  rt_idx;
  logic [2:0]  rd_idx;
  logic [2:0]  funct;
  logic [15:0] imm_ext;

  assign op      = id_instr[15:12];
  assign rs_idx  = id_instr[11:9];
  assign rt_idx  = id_instr[8:6];
  assign rd_idx  = id_instr[5:3];
  assign funct   = id_instr[2:0];
  assign imm_ext = {{10{id_instr[5]}}, id_instr[5:0]};

  logic [15:0] rs_operand;
  logic [15:0] rt_operand;

`ifdef FWD_EN
  // EX/MEM is the younger result, so it wins over MEM/WB.
  always_comb begin
    rs_operand = rs_data;
    if (exmem_reg_write && (exmem_rd != 3'd0) && (exmem_rd == rs_idx)) begin
      rs_operand = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 3'd0) && (memwb_rd == rs_idx)) begin
      rs_operand = memwb_result;
    end
  end

  always_comb begin
    rt_operand = rt_data;
    if (exmem_reg_write && (exmem_rd != 3'd0) && (exmem_rd == rt_idx)) begin
      rt_operand = exmem_result;
    end else if (memwb_reg_write && (memwb_rd != 3'd0) && (memwb_rd == rt_idx)) begin
      rt_operand = memwb_result;
    end
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd, exmem_result,
                        memwb_reg_write, memwb_rd, memwb_result};
  assign rs_operand = rs_data;
  assign rt_operand = rt_data;
`endif

  logic [15:0] dec_b;
  logic [2:0]  dec_alu;
  logic [2:0]  dec_rd;
  logic        dec_reg_write;
  logic        dec_mem_read;
  logic        dec_mem_write;
  logic        dec_branch;
  logic        dec_illegal;

  always_comb begin
    dec_b         = rt_operand;
    dec_alu       = ALU_ADD;
    dec_rd        = 3'd0;
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_branch    = 1'b0;
    dec_illegal   = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (funct > ALU_SLT) begin
          dec_illegal = 1'b1;
        end else begin
          dec_alu       = funct;
          dec_rd        = rd_idx;
          dec_reg_write = 1'b1;
        end
      end
      OP_ADDI: begin
        dec_b         = imm_ext;
        dec_rd        = rt_idx;
        dec_reg_write = 1'b1;
      end
      OP_LW: begin
        dec_b         = imm_ext;
        dec_rd        = rt_idx;
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
      end
      OP_SW: begin
        dec_b         = imm_ext;
        dec_mem_write = 1'b1;
      end
      OP_BEQ: begin
        dec_alu    = ALU_SUB;
        dec_branch = 1'b1;
      end
      default: dec_illegal = 1'b1;
    endcase
    // Writes to r0 are architecturally discarded.
    if (dec_rd == 3'd0) begin
      dec_reg_write = 1'b0;
    end
  end

  logic        valid_q, valid_d;
  logic [15:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [2:0]  alu_q, alu_d;
  logic [2:0]  rd_q, rd_d;
  logic        reg_write_q, reg_write_d;
  logic        mem_read_q, mem_read_d;
  logic        mem_write_q, mem_write_d;
  logic        branch_q, branch_d;
  logic [15:0] store_q, store_d;
  logic        illegal_q, illegal_d;
  logic        transfer;

  assign id_ready = ex_ready | ~valid_q;
  assign transfer = id_valid & id_ready;

  always_comb begin
    valid_d     = valid_q;
    a_d         = a_q;
    b_d         = b_q;
    alu_d       = alu_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    branch_d    = branch_q;
    store_d     = store_q;
    illegal_d   = illegal_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
      mem_read_d  = 1'b0;
      mem_write_d = 1'b0;
      branch_d    = 1'b0;
      illegal_d   = 1'b0;
    end else if (transfer) begin
      valid_d     = 1'b1;
      a_d         = rs_operand;
      b_d         = dec_b;
      alu_d       = dec_alu;
      rd_d        = dec_rd;
      reg_write_d = dec_reg_write;
      mem_read_d  = dec_mem_read;
      mem_write_d = dec_mem_write;
      branch_d    = dec_branch;
      store_d     = rt_operand;
      illegal_d   = dec_illegal;
    end else if (ex_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q     <= 1'b0;
      a_q         <= 16'd0;
      b_q         <= 16'd0;
      alu_q       <= 3'd0;
      rd_q        <= 3'd0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      branch_q    <= 1'b0;
      store_q     <= 16'd0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      a_q         <= a_d;
      b_q         <= b_d;
      alu_q       <= alu_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      branch_q    <= branch_d;
      store_q     <= store_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid       = valid_q;
  assign ex_inputA      = a_q;
  assign ex_inputB      = b_q;
  assign ex_alu_control = alu_q;
  assign ex_rd          = rd_q;
  assign ex_reg_write   = reg_write_q;
  assign ex_mem_read    = mem_read_q;
  assign ex_mem_write   = mem_write_q;
  assign ex_branch      = branch_q;
  assign ex_store_data  = store_q;
  assign ex_illegal     = illegal_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with hand-computed expectations.
// Forwarding expectations follow whether FWD_EN is defined for this build.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic        id_ready;
  logic [15:0] id_instr;
  logic [15:0] rs_data, rt_data;
  logic        flush;
  logic        ex_ready;
  logic        ex_valid;
  logic [15:0] ex_inputA, ex_inputB;
  logic [2:0]  ex_alu_control;
  logic [2:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write, ex_branch;
  logic [15:0] ex_store_data;
  logic        ex_illegal;
  logic        exmem_reg_write;
  logic [2:0]  exmem_rd;
  logic [15:0] exmem_result;
  logic        memwb_reg_write;
  logic [2:0]  memwb_rd;
  logic [15:0] memwb_result;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr),
    .rs_data(rs_data), .rt_data(rt_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid),
    .ex_inputA(ex_inputA), .ex_inputB(ex_inputB),
    .ex_alu_control(ex_alu_control), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_store_data(ex_store_data), .ex_illegal(ex_illegal),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result)
  );

  task automatic checkOutput(input string tag, input logic [15:0] actual, input logic [15:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
  endtask

  task automatic applyStimulus(input logic valid, input logic [15:0] instr,
                               input logic [15:0] rs, input logic [15:0] rt,
                               input logic rdy, input logic fl);
    id_valid = valid;
    id_instr = instr;
    rs_data  = rs;
    rt_data  = rt;
    ex_ready = rdy;
    flush    = fl;
  endtask

  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Checks the full control bundle: {illegal, branch, mem_write, mem_read, reg_write, valid}.
  task automatic checkCtrl(input string tag, input logic [5:0] expected);
    checkOutput(tag, {10'd0, ex_illegal, ex_branch, ex_mem_write, ex_mem_read, ex_reg_write, ex_valid},
                {10'd0, expected});
  endtask

  initial begin
    exmem_reg_write = 1'b0; exmem_rd = 3'd0; exmem_result = 16'h0;
    memwb_reg_write = 1'b0; memwb_rd = 3'd0; memwb_result = 16'h0;
    reset = 1'b1;
    applyStimulus(1'b1, 16'h0298, 16'd5, 16'd7, 1'b1, 1'b0);
    repeat (2) stepClock();
    checkCtrl("reset_ctrl", 6'b000000);
    checkOutput("reset_A", ex_inputA, 16'h0);
    checkOutput("reset_B", ex_inputB, 16'h0);
    checkOutput("reset_alu", {13'd0, ex_alu_control}, 16'h0);
    checkOutput("reset_rd", {13'd0, ex_rd}, 16'h0);
    checkOutput("reset_idready", {15'd0, id_ready}, 16'h1);

    // ADD r3,r1,r2
    reset = 1'b0;
    stepClock();
    checkCtrl("add_ctrl", 6'b000011);
    checkOutput("add_A", ex_inputA, 16'd5);
    checkOutput("add_B", ex_inputB, 16'd7);
    checkOutput("add_alu", {13'd0, ex_alu_control}, 16'h0);
    checkOutput("add_rd", {13'd0, ex_rd}, 16'd3);

    // ADDI r4,r1,-1
    applyStimulus(1'b1, 16'h133F, 16'd10, 16'd99, 1'b1, 1'b0);
    stepClock();
    checkOutput("addi_A", ex_inputA, 16'd10);
    checkOutput("addi_B", ex_inputB, 16'hFFFF);
    checkOutput("addi_alu", {13'd0, ex_alu_control}, 16'h0);
    checkOutput("addi_rd", {13'd0, ex_rd}, 16'd4);
    checkCtrl("addi_ctrl", 6'b000011);

    // BEQ r1,r2
    applyStimulus(1'b1, 16'h4280, 16'd3, 16'd9, 1'b1, 1'b0);
    stepClock();
    checkOutput("beq_alu", {13'd0, ex_alu_control}, 16'd1);
    checkOutput("beq_B", ex_inputB, 16'd9);
    checkCtrl("beq_ctrl", 6'b010001);

    // LW r5,2(r1)
    applyStimulus(1'b1, 16'h2342, 16'd100, 16'd0, 1'b1, 1'b0);
    stepClock();
    checkOutput("lw_B", ex_inputB, 16'd2);
    checkOutput("lw_rd", {13'd0, ex_rd}, 16'd5);
    checkCtrl("lw_ctrl", 6'b000111);

    // SW r2,-2(r1)
    applyStimulus(1'b1, 16'h32BE, 16'd20, 16'h1234, 1'b1, 1'b0);
    stepClock();
    checkOutput("sw_A", ex_inputA, 16'd20);
    checkOutput("sw_B", ex_inputB, 16'hFFFE);
    checkOutput("sw_store", ex_store_data, 16'h1234);
    checkCtrl("sw_ctrl", 6'b001001);

    // ADDI to r0 must not write
    applyStimulus(1'b1, 16'h1201, 16'd1, 16'd0, 1'b1, 1'b0);
    stepClock();
    checkCtrl("r0_ctrl", 6'b000001);

    // Stall: hold ADD while SUB r6,r1,r2 waits
    applyStimulus(1'b1, 16'h0298, 16'd5, 16'd7, 1'b1, 1'b0);
    stepClock();
    applyStimulus(1'b1, 16'h02B1, 16'd50, 16'd8, 1'b0, 1'b0);
    #1;
    checkOutput("stall_idready", {15'd0, id_ready}, 16'h0);
    for (int i = 0; i < 3; i++) begin
      stepClock();
      checkOutput($sformatf("stall%0d_A", i), ex_inputA, 16'd5);
      checkOutput($sformatf("stall%0d_alu", i), {13'd0, ex_alu_control}, 16'h0);
      checkOutput($sformatf("stall%0d_rd", i), {13'd0, ex_rd}, 16'd3);
      checkCtrl($sformatf("stall%0d_ctrl", i), 6'b000011);
    end
    ex_ready = 1'b1;
    #1;
    checkOutput("unstall_idready", {15'd0, id_ready}, 16'h1);
    stepClock();
    checkOutput("unstall_A", ex_inputA, 16'd50);
    checkOutput("unstall_B", ex_inputB, 16'd8);
    checkOutput("unstall_alu", {13'd0, ex_alu_control}, 16'd1);
    checkOutput("unstall_rd", {13'd0, ex_rd}, 16'd6);

    // Flush drops the same-cycle instruction
    applyStimulus(1'b1, 16'h0298, 16'd5, 16'd7, 1'b1, 1'b1);
    stepClock();
    checkCtrl("flush_ctrl", 6'b000000);
    applyStimulus(1'b0, 16'h0298, 16'd5, 16'd7, 1'b1, 1'b0);
    stepClock();
    checkCtrl("flush_drop", 6'b000000);

    // Illegal opcode and illegal funct
    applyStimulus(1'b1, 16'hF298, 16'd5, 16'd7, 1'b1, 1'b0);
    stepClock();
    checkCtrl("illop_ctrl", 6'b100001);
    checkOutput("illop_alu", {13'd0, ex_alu_control}, 16'h0);
    applyStimulus(1'b1, 16'h029E, 16'd5, 16'd7, 1'b1, 1'b0);
    stepClock();
    checkCtrl("illfn_ctrl", 6'b100001);
    checkOutput("illfn_alu", {13'd0, ex_alu_control}, 16'h0);

    // Drain
    applyStimulus(1'b0, 16'h0000, 16'd0, 16'd0, 1'b1, 1'b0);
    stepClock();
    checkOutput("drain_valid", {15'd0, ex_valid}, 16'h0);

    // Forwarding: ADD r3,r2,r1 with both sources targeting r2
    exmem_reg_write = 1'b1; exmem_rd = 3'd2; exmem_result = 16'h00AA;
    memwb_reg_write = 1'b1; memwb_rd = 3'd2; memwb_result = 16'h00BB;
    applyStimulus(1'b1, 16'h0458, 16'h1111, 16'h2222, 1'b1, 1'b0);
    stepClock();
`ifdef FWD_EN
    checkOutput("fwd_exmem", ex_inputA, 16'h00AA);
`else
    checkOutput("fwd_exmem", ex_inputA, 16'h1111);
`endif
    checkOutput("fwd_rt", ex_inputB, 16'h2222);
    exmem_rd = 3'd0;
    stepClock();
`ifdef FWD_EN
    checkOutput("fwd_memwb", ex_inputA, 16'h00BB);
`else
    checkOutput("fwd_memwb", ex_inputA, 16'h1111);
`endif
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;

    // Reset mid-stall clears immediately, before any clock edge
    applyStimulus(1'b1, 16'h0298, 16'd5, 16'd7, 1'b0, 1'b0);
    stepClock();
    checkCtrl("prereset_ctrl", 6'b000011);
    #2;
    reset = 1'b1;
    #1;
    checkCtrl("asyncreset_ctrl", 6'b000000);
    checkOutput("asyncreset_A", ex_inputA, 16'h0);
    checkOutput("asyncreset_idready", {15'd0, id_ready}, 16'h1);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
